// File: rtl/ex_fpu_sequencer_if.sv
// ex_fpu_sequencer_if: groups the ID/EX operand bundle, the FP datapath
// launch/complete signals and the MEM/WB result handshake of the EX-stage
// floating-point sequencer. The slave modport is the sequencer's view, the
// master modport is the surrounding pipeline/datapath view.
interface ex_fpu_sequencer_if;
    // ID/EX bundle
    logic        ex_valid;
    logic [4:0]  ex_falu_opcode;
    logic [31:0] ex_fp_rdata1;
    logic [31:0] ex_fp_rdata2;
    logic [2:0]  ex_rm;
    logic [4:0]  ex_rd_addr;
    logic        ex_wb_fp_en;
    logic        ex_wb_int_en;
    logic        flush;
    logic        id_stall;
    // FP datapath
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [2:0]  fpu_rm;
    logic        fpu_kill;
    logic        fpu_done;
    logic [31:0] fpu_result;
    // MEM/WB
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_fp_en;
    logic        wb_int_en;
    logic        fpu_timeout;

    modport slave (
        input  ex_valid, ex_falu_opcode, ex_fp_rdata1, ex_fp_rdata2, ex_rm,
               ex_rd_addr, ex_wb_fp_en, ex_wb_int_en, flush,
               fpu_done, fpu_result, wb_ready,
        output id_stall, fpu_start, fpu_op, fpu_a, fpu_b, fpu_rm, fpu_kill,
               wb_valid, wb_data, wb_rd_addr, wb_fp_en, wb_int_en, fpu_timeout
    );

    modport master (
        output ex_valid, ex_falu_opcode, ex_fp_rdata1, ex_fp_rdata2, ex_rm,
               ex_rd_addr, ex_wb_fp_en, ex_wb_int_en, flush,
               fpu_done, fpu_result, wb_ready,
        input  id_stall, fpu_start, fpu_op, fpu_a, fpu_b, fpu_rm, fpu_kill,
               wb_valid, wb_data, wb_rd_addr, wb_fp_en, wb_int_en, fpu_timeout
    );
endinterface

// File: rtl/ex_fpu_sequencer.sv
// ex_fpu_sequencer: EX-stage sequencer for one in-flight FP operation.
// Captures an op from ID/EX, launches it on the FP datapath, tracks its
// latency (fixed counter, or done strobe for DIV/SQRT), and hands the result
// to MEM/WB with valid/ready. Stalls ID while busy.
// Optional: define FPU_WATCHDOG_EN to add a timeout on done-driven ops that
// kills the op and returns a canonical qNaN with a sticky fpu_timeout flag.
module ex_fpu_sequencer #(
    parameter int         FIXED_LAT      = 3,
    parameter logic [4:0] DIV_OPCODE     = 5'd3,
    parameter logic [4:0] SQRT_OPCODE    = 5'd11,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                rst,
    ex_fpu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic        accept_s;
    logic        capture_s;
    logic        kill_s;
    logic        timeout_s;
    logic        done_op_s;
    logic        wd_expired_s;
    logic [3:0]  cnt_r;
    logic        start_r;
    logic        kill_r;
    logic        wb_valid_r;
    logic [4:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [2:0]  rm_r;
    logic [4:0]  rd_r;
    logic        fp_en_r;
    logic        int_en_r;
    logic [31:0] wb_data_r;
    logic        timeout_r;

    assign done_op_s = (bus.ex_falu_opcode == DIV_OPCODE) ||
                       (bus.ex_falu_opcode == SQRT_OPCODE);

    // Next-state and one-cycle control decode; flush outranks completion.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        kill_s     = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.ex_valid && !bus.flush) begin
                    accept_s = 1'b1;
                    if (done_op_s) begin
                        state_nx_s = WAIT;
                    end else begin
                        state_nx_s = COUNT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COUNT: begin
                if (bus.flush) begin
                    kill_s     = 1'b1;
                    state_nx_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    capture_s  = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = COUNT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    kill_s     = 1'b1;
                    state_nx_s = IDLE;
                end else if (bus.fpu_done) begin
                    capture_s  = 1'b1;
                    state_nx_s = RESP;
                end else if (wd_expired_s) begin
                    timeout_s  = 1'b1;
                    kill_s     = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (bus.wb_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered launch/abort pulses and result-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_r    <= 1'b0;
            kill_r     <= 1'b0;
            wb_valid_r <= 1'b0;
        end else begin
            start_r    <= accept_s;
            kill_r     <= kill_s;
            wb_valid_r <= (state_nx_s == RESP);
        end
    end

    // Operation latch: held from launch until the next accepted op.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 5'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            rm_r     <= 3'd0;
            rd_r     <= 5'd0;
            fp_en_r  <= 1'b0;
            int_en_r <= 1'b0;
        end else if (accept_s) begin
            op_r     <= bus.ex_falu_opcode;
            a_r      <= bus.ex_fp_rdata1;
            b_r      <= bus.ex_fp_rdata2;
            rm_r     <= bus.ex_rm;
            rd_r     <= bus.ex_rd_addr;
            fp_en_r  <= bus.ex_wb_fp_en;
            int_en_r <= bus.ex_wb_int_en;
        end
    end

    // Fixed-latency countdown; loaded so the result lands FIXED_LAT after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'(FIXED_LAT - 1);
        end else if ((state_r == COUNT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Result register: datapath result on completion, qNaN on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_r <= 32'd0;
        end else if (capture_s) begin
            wb_data_r <= bus.fpu_result;
        end else if (timeout_s) begin
            wb_data_r <= 32'h7FC0_0000;
        end
    end

`ifdef FPU_WATCHDOG_EN
    logic [6:0] wd_cnt_r;

    assign wd_expired_s = (wd_cnt_r == 7'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT cycles, zero on every entry to WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= 7'd0;
        end else if (state_r != WAIT) begin
            wd_cnt_r <= 7'd0;
        end else begin
            wd_cnt_r <= wd_cnt_r + 7'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (timeout_s) begin
            timeout_r <= 1'b1;
        end
    end
`else
    assign wd_expired_s = 1'b0;
    assign timeout_r    = 1'b0;
`endif

    assign bus.id_stall    = (state_r != IDLE);
    assign bus.fpu_start   = start_r;
    assign bus.fpu_kill    = kill_r;
    assign bus.fpu_op      = op_r;
    assign bus.fpu_a       = a_r;
    assign bus.fpu_b       = b_r;
    assign bus.fpu_rm      = rm_r;
    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_data     = wb_data_r;
    assign bus.wb_rd_addr  = rd_r;
    assign bus.wb_fp_en    = fp_en_r;
    assign bus.wb_int_en   = int_en_r;
    assign bus.fpu_timeout = timeout_r;

endmodule

// File: tb/tb_ex_fpu_sequencer.sv
// tb_ex_fpu_sequencer: scoreboard bench for ex_fpu_sequencer. Fixed-latency
// results come from a cycle-stamped fpu_result so the sampling cycle is
// checked; done-driven results are supplied with the fpu_done pulse.
module tb_ex_fpu_sequencer;
    localparam int LAT = 3;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fp;
        logic        in_;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc_r = 32'd0;
    logic [31:0] div_val = 32'd0;
    int          n_vec = 0;
    int          n_miss = 0;
    exp_t        sb_q[$];

    ex_fpu_sequencer_if bus_if ();

    ex_fpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_r <= cyc_r + 32'd1;

    assign bus_if.fpu_result = bus_if.fpu_done ? div_val : {16'hC0DE, cyc_r[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [4:0] rd, input logic fp,
                         input logic in_);
        bus_if.ex_falu_opcode = opc;
        bus_if.ex_fp_rdata1   = a;
        bus_if.ex_fp_rdata2   = b;
        bus_if.ex_rm          = rm;
        bus_if.ex_rd_addr     = rd;
        bus_if.ex_wb_fp_en    = fp;
        bus_if.ex_wb_int_en   = in_;
        bus_if.ex_valid       = 1'b1;
        step();
        bus_if.ex_valid       = 1'b0;
        bus_if.ex_fp_rdata1   = 32'h0BAD_0BAD;
        bus_if.ex_fp_rdata2   = 32'h0BAD_0BAD;
    endtask

    // misc[0]: flush during RESP backpressure; misc[1]: stray fpu_done in COUNT
    task automatic run_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm, input logic [4:0] rd, input logic fp,
                          input logic in_, input int done_dly, input logic [31:0] res,
                          input int hold, input logic [1:0] misc);
        exp_t        e;
        exp_t        g;
        int          n;
        bit          ok;
        bit          is_div;
        logic [31:0] s;
        logic [31:0] held;
        is_div = (opc == 5'd3) || (opc == 5'd11);
        chk("idle_stall", {31'd0, bus_if.id_stall}, 32'd0);
        issue(opc, a, b, rm, rd, fp, in_);
        s = cyc_r;
        chk("start", {31'd0, bus_if.fpu_start}, 32'd1);
        chk("busy_stall", {31'd0, bus_if.id_stall}, 32'd1);
        chk("fpu_op", {27'd0, bus_if.fpu_op}, {27'd0, opc});
        chk("fpu_a", bus_if.fpu_a, a);
        chk("fpu_b", bus_if.fpu_b, b);
        chk("fpu_rm", {29'd0, bus_if.fpu_rm}, {29'd0, rm});
        e.rd = rd; e.fp = fp; e.in_ = in_;
        if (is_div) begin
            e.data = res;
            sb_q.push_back(e);
            ok = 1'b1;
            for (int i = 0; i < done_dly; i++) begin
                step();
                if (bus_if.wb_valid !== 1'b0 || bus_if.id_stall !== 1'b1) ok = 1'b0;
            end
            chk("wait_hold", {31'd0, ok}, 32'd1);
            div_val = res;
            bus_if.fpu_done = 1'b1;
            step();
            bus_if.fpu_done = 1'b0;
            chk("done_valid", {31'd0, bus_if.wb_valid}, 32'd1);
        end else begin
            e.data = {16'hC0DE, 16'(s + 32'(LAT) - 32'd1)};
            sb_q.push_back(e);
            if (misc[1]) begin
                div_val = 32'hDEAD_BEEF;
                bus_if.fpu_done = 1'b1;
            end
            n = 0;
            while (bus_if.wb_valid !== 1'b1 && n < 20) begin
                step();
                bus_if.fpu_done = 1'b0;
                n++;
            end
            chk("latency", n, LAT);
        end
        chk("a_stable", bus_if.fpu_a, a);
        chk("resp_stall", {31'd0, bus_if.id_stall}, 32'd1);
        held = bus_if.wb_data;
        ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus_if.wb_ready = 1'b0;
            bus_if.flush    = misc[0];
            issue(5'd0, 32'h1111_1111, 32'h2222_2222, 3'd0, 5'd1, 1'b1, 1'b0);
            if (bus_if.wb_valid !== 1'b1 || bus_if.wb_data !== held ||
                bus_if.fpu_kill !== 1'b0 || bus_if.fpu_start !== 1'b0) ok = 1'b0;
        end
        bus_if.flush = 1'b0;
        chk("backpressure", {31'd0, ok}, 32'd1);
        if (sb_q.size() > 0) begin
            g = sb_q.pop_front();
            chk("wb_data", bus_if.wb_data, g.data);
            chk("wb_rd", {27'd0, bus_if.wb_rd_addr}, {27'd0, g.rd});
            chk("wb_en", {30'd0, bus_if.wb_fp_en, bus_if.wb_int_en}, {30'd0, g.fp, g.in_});
        end else begin
            chk("sb_empty", 32'd0, 32'd1);
        end
        bus_if.wb_ready = 1'b1;
        step();
        bus_if.wb_ready = 1'b0;
        chk("post_valid", {31'd0, bus_if.wb_valid}, 32'd0);
        chk("post_stall", {31'd0, bus_if.id_stall}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        bus_if.ex_valid = 1'b0; bus_if.ex_falu_opcode = 5'd0;
        bus_if.ex_fp_rdata1 = 32'd0; bus_if.ex_fp_rdata2 = 32'd0;
        bus_if.ex_rm = 3'd0; bus_if.ex_rd_addr = 5'd0;
        bus_if.ex_wb_fp_en = 1'b0; bus_if.ex_wb_int_en = 1'b0;
        bus_if.flush = 1'b0; bus_if.fpu_done = 1'b0; bus_if.wb_ready = 1'b0;
        repeat (3) step();
        chk("rst_outs", {bus_if.id_stall, bus_if.fpu_start, bus_if.fpu_kill, bus_if.wb_valid,
                         bus_if.fpu_timeout, bus_if.wb_fp_en, bus_if.wb_int_en, 25'd0}, 32'd0);
        chk("rst_data", bus_if.wb_data | bus_if.fpu_a | bus_if.fpu_b, 32'd0);
        rst = 1'b0;
        step();

        run_op(5'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 5'd7, 1'b1, 1'b0, 0, 32'd0, 0, 2'b00);
        run_op(5'd3, 32'h3F80_0000, 32'h4000_0000, 3'd1, 5'd9, 1'b1, 1'b0, 17, 32'h3F00_0000, 0, 2'b00);
        run_op(5'd11, 32'h4080_0000, 32'd0, 3'd2, 5'd12, 1'b0, 1'b1, 4, 32'h4000_0000, 0, 2'b00);
        run_op(5'd4, 32'h4040_0000, 32'h3F80_0000, 3'd3, 5'd3, 1'b1, 1'b1, 0, 32'd0, 5, 2'b01);
        run_op(5'd1, 32'hC000_0000, 32'h4100_0000, 3'd4, 5'd31, 1'b0, 1'b1, 0, 32'd0, 0, 2'b10);

        // flush in IDLE blocks acceptance
        bus_if.flush = 1'b1;
        issue(5'd0, 32'h1, 32'h2, 3'd0, 5'd5, 1'b1, 1'b0);
        bus_if.flush = 1'b0;
        chk("idle_flush", {30'd0, bus_if.fpu_start, bus_if.id_stall}, 32'd0);

        // flush in WAIT at cycle 4
        issue(5'd3, 32'h4000_0000, 32'h4000_0000, 3'd0, 5'd6, 1'b1, 1'b0);
        repeat (3) step();
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        chk("wflush_kill", {29'd0, bus_if.fpu_kill, bus_if.wb_valid, bus_if.id_stall}, 32'd4);
        step();
        chk("wflush_after", {30'd0, bus_if.fpu_kill, bus_if.wb_valid}, 32'd0);
        run_op(5'd2, 32'h4110_0000, 32'h4120_0000, 3'd0, 5'd10, 1'b1, 1'b0, 0, 32'd0, 0, 2'b00);

        // flush on the fpu_start cycle still kills, without overlapping start
        issue(5'd0, 32'h5, 32'h6, 3'd0, 5'd11, 1'b1, 1'b0);
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        chk("sflush_kill", {29'd0, bus_if.fpu_kill, bus_if.fpu_start, bus_if.id_stall}, 32'd4);

        // reset during COUNT
        issue(5'd0, 32'h7, 32'h8, 3'd5, 5'd13, 1'b1, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("crst_outs", {bus_if.id_stall, bus_if.fpu_start, bus_if.fpu_kill, bus_if.wb_valid,
                          bus_if.wb_fp_en, bus_if.wb_int_en, 26'd0}, 32'd0);
        chk("crst_data", bus_if.wb_data | bus_if.fpu_a | {27'd0, bus_if.wb_rd_addr}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.wb_valid !== 1'b0 || bus_if.fpu_kill !== 1'b0) ok = 1'b0;
        end
        chk("crst_quiet", {31'd0, ok}, 32'd1);

`ifdef FPU_WATCHDOG_EN
        issue(5'd11, 32'h4080_0000, 32'd0, 3'd0, 5'd14, 1'b1, 1'b0);
        n = 0;
        while (bus_if.wb_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("wd_latency", n, 64);
        chk("wd_flags", {30'd0, bus_if.fpu_timeout, bus_if.fpu_kill}, 32'd3);
        chk("wd_qnan", bus_if.wb_data, 32'h7FC0_0000);
        bus_if.wb_ready = 1'b1;
        step();
        bus_if.wb_ready = 1'b0;
        chk("wd_sticky", {30'd0, bus_if.fpu_timeout, bus_if.wb_valid}, 32'd2);
`else
        issue(5'd11, 32'h4080_0000, 32'd0, 3'd0, 5'd14, 1'b1, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus_if.wb_valid !== 1'b0 || bus_if.id_stall !== 1'b1 ||
                bus_if.fpu_timeout !== 1'b0) ok = 1'b0;
        end
        chk("nowd_hold", {31'd0, ok}, 32'd1);
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        chk("nowd_kill", {30'd0, bus_if.fpu_kill, bus_if.id_stall}, 32'd2);
        n = 0;
`endif
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
